mem_arbiter_fsm: RTL and testbench
==================================

Name: mem_arbiter_fsm

Overview:
- Sequential arbiter sharing one multi-cycle RAM port between the instruction-fetch requester and the data requester of the MIPS datapath.
- Sits between the datapath's iREN/dREN/dWEN request lines and the RAM model.
- Registers the grant, holds it until the RAM reports ACCESS or ERROR, enforces data priority with an instruction starvation guard, and times out hung accesses.

Parameters:
- WORD_W, 32, width of addresses and data words.
- MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request waits.
- TIMEOUT, 64, cycles in an access state before a forced error completion.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  WORD_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are set.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- iwait  out  1  instruction request not completing this cycle.
- dwait  out  1  data request not completing this cycle.
- iload  out  WORD_W  instruction word; valid when iREN=1 and iwait=0.
- dload  out  WORD_W  data load word; valid when dREN=1 and dwait=0.
- mem_err  out  1  one-cycle pulse on ERROR or timeout completion.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state=IDLE, dstreak=0, timer=0. Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, mem_err=0, iload=dload=0. iwait=iREN and dwait=(dREN|dWEN), i.e. combinationally high for any pending request.
- States: IDLE, I_ACC, D_ACC.
- IDLE arbitration, evaluated each edge:
  - Data pending and instruction not pending -> D_ACC.
  - Instruction only -> I_ACC.
  - Both pending: if dstreak>=MAX_DSTREAK -> I_ACC, else -> D_ACC.
  - No RAM strobes are driven in IDLE, so minimum latency is 1 arbitration cycle plus the RAM latency.
- I_ACC: drive ramREN=1 and ramaddr=iaddr.
- D_ACC: drive ramaddr=daddr. If dWEN: ramWEN=1, ramstore=dstore, ramREN=0. Otherwise ramREN=1.
- Completion, in the granted state:
  - ramstate==ACCESS: clear the owner's wait that same cycle. Drive iload or dload from ramload (combinational pass-through). Next state IDLE.
  - ramstate==ERROR: complete the same way, with mem_err=1 and load data forced to 0.
- Timer:
  - Cleared on entry to an access state; increments each cycle in that state.
  - When timer==TIMEOUT-1 without ACCESS/ERROR: force completion with mem_err=1, load data 0, next state IDLE.
- dstreak update at each completion:
  - Data completion while iREN=1 -> saturating increment.
  - Instruction completion -> 0.
  - Data completion with iREN=0 -> 0.
- Grant is non-preemptive: a new higher-priority request never interrupts an access in progress.
- Abort: if the owner drops its request mid-access (e.g. both dREN and dWEN fall in D_ACC):
  - strobes drop that cycle;
  - next state IDLE;
  - no completion, no mem_err, dstreak unchanged.
- Changing dREN to dWEN mid-access is a protocol violation; the strobes follow the inputs combinationally, and no recovery is required.
- After each completion, at least one IDLE cycle follows before the next grant, so back-to-back accesses are separated by one cycle.
- Asynchronous reset mid-access drops strobes immediately and returns to IDLE; the in-flight access is discarded.
- The non-owner's wait stays high throughout.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, with RAM returning ACCESS on the 2nd cycle after the strobe and ramload=0x8C010004 -> ramREN high for 2 cycles with ramaddr=0x40. iwait=0 and iload=0x8C010004 in the ACCESS cycle. State is IDLE the next cycle.
- iREN and dREN held together, daddr=0x100, with the data requester re-requesting continuously and MAX_DSTREAK=4 -> 4 data grants, then 1 instruction grant, then dstreak=0 and the data grant resumes.
- dWEN=1 and dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. dwait=0 in the ACCESS cycle. mem_err stays 0.
- RAM held BUSY forever with TIMEOUT=64 -> exactly 64 cycles of ramREN. Then dwait=0, mem_err=1 for one cycle, dload=0, state IDLE.
- RAM returns ERROR on the 1st access cycle -> completion that cycle with mem_err=1 and load data 0.
- Separately, dREN dropped in the 2nd D_ACC cycle -> ramREN=0 that cycle, IDLE next, no mem_err.
- nRST pulled low mid-I_ACC, not aligned to CLK -> ramREN=0 immediately. After release, iREN still high -> a fresh arbitration cycle, then a new access.

Source files
------------

// File: rtl/mem_arbiter_fsm.sv
// Shares one multi-cycle RAM port between instruction fetch and data access.
// Data has priority, with a streak limit that keeps instruction fetch from starving.
module mem_arbiter_fsm #(
   parameter int WORD_W      = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              mem_err,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

   state_t          state, nextstate;
   logic [SW-1:0]   dstreak;
   logic [TW-1:0]   timer;
   logic            dreq, rspok, rspbad, timeup;
   logic            icomplete, dcomplete;

   assign dreq   = dREN | dWEN;
   assign timeup = (timer == TW'(TIMEOUT - 1));
   assign rspok  = (ramstate == RAM_ACCESS);
   assign rspbad = (ramstate == RAM_ERROR) || (timeup && !rspok);

   // Arbitration, strobes and completion; an owner that drops its request aborts quietly.
   always_comb begin
      nextstate = state;
      iwait     = iREN;
      dwait     = dreq;
      iload     = '0;
      dload     = '0;
      mem_err   = 1'b0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      icomplete = 1'b0;
      dcomplete = 1'b0;
      unique case (state)
         IDLE: begin
            if (dreq && !(iREN && (dstreak >= SW'(MAX_DSTREAK))))
               nextstate = D_ACC;
            else if (iREN)
               nextstate = I_ACC;
         end
         I_ACC: begin
            if (!iREN) begin
               nextstate = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (rspok || rspbad) begin
                  icomplete = 1'b1;
                  iwait     = 1'b0;
                  mem_err   = rspbad;
                  iload     = rspok ? ramload : '0;
                  nextstate = IDLE;
               end
            end
         end
         D_ACC: begin
            if (!dreq) begin
               nextstate = IDLE;
            end else begin
               ramaddr  = daddr;
               ramWEN   = dWEN;
               ramREN   = !dWEN;
               ramstore = dWEN ? dstore : '0;
               if (rspok || rspbad) begin
                  dcomplete = 1'b1;
                  dwait     = 1'b0;
                  mem_err   = rspbad;
                  dload     = rspok ? ramload : '0;
                  nextstate = IDLE;
               end
            end
         end
         default: nextstate = IDLE;
      endcase
   end

   // State, access timer and data streak counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         timer   <= '0;
         dstreak <= '0;
      end else begin
         state <= nextstate;
         if (state != IDLE && nextstate == state)
            timer <= timer + TW'(1);
         else
            timer <= '0;
         if (dcomplete) begin
            if (!iREN)
               dstreak <= '0;
            else if (dstreak < SW'(MAX_DSTREAK))
               dstreak <= dstreak + SW'(1);
         end else if (icomplete) begin
            dstreak <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Bench for mem_arbiter_fsm: a latency-programmable RAM, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter_fsm;

   localparam int WORD_W      = 32;
   localparam int MAX_DSTREAK = 4;
   localparam int TIMEOUT     = 64;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              iREN, dREN, dWEN;
   logic [WORD_W-1:0] iaddr, daddr, dstore;
   logic              iwait, dwait, mem_err, ramREN, ramWEN;
   logic [WORD_W-1:0] iload, dload, ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   int checks = 0;
   int failures = 0;

   // RAM behaviour: response arrives on strobe cycle ramLat (0 = never), ERROR if ramErr.
   int ramLat = 2;
   bit ramErr = 1'b0;
   int strobeCnt = 0;

   mem_arbiter_fsm #(.WORD_W(WORD_W), .MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .mem_err(mem_err),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C010004;
      return (a * 3) ^ 32'h1234_0000;
   endfunction

   always @(posedge CLK) strobeCnt <= (ramREN | ramWEN) ? strobeCnt + 1 : 0;

   always_comb begin
      ramload = memWord(ramaddr);
      if (!(ramREN | ramWEN))
         ramstate = 2'd0;
      else if (ramLat != 0 && strobeCnt + 1 == ramLat)
         ramstate = ramErr ? 2'd3 : 2'd2;
      else
         ramstate = 2'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit i, input logic [31:0] ia, input bit dr, input bit dw,
                                input logic [31:0] da, input logic [31:0] ds,
                                input int lat, input bit err);
      @(posedge CLK);
      #1;
      iREN = i; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
      ramLat = lat; ramErr = err;
   endtask

   // Reference model: owner 0 none, 1 instruction, 2 data; access age from a cycle count.
   int cyc = 0, startCyc = 0, mOwner = 0, mStreak = 0, nOwner, elapsed, rsp;
   logic eIwait, eDwait, eErr, eRen, eWen, mdreq;
   logic [31:0] eIload, eDload, eAddr, eStore;
   bit done;

   always @(negedge CLK or negedge nRST) begin
      if (!nRST) begin
         mOwner = 0; mStreak = 0; startCyc = 0;
      end else begin
         mdreq  = dREN | dWEN;
         eIwait = iREN; eDwait = mdreq; eIload = 0; eDload = 0; eErr = 0;
         eRen = 0; eWen = 0; eAddr = 0; eStore = 0;
         elapsed = cyc - startCyc;
         rsp = (ramLat != 0 && elapsed + 1 == ramLat) ? (ramErr ? 3 : 2) : 1;
         done = (rsp != 1) || (elapsed == TIMEOUT - 1);
         nOwner = mOwner;
         case (mOwner)
            0: begin
               if (mdreq && !(iREN && mStreak >= MAX_DSTREAK)) nOwner = 2;
               else if (iREN) nOwner = 1;
               if (nOwner != 0) startCyc = cyc + 1;
            end
            1: begin
               nOwner = 0;
               if (iREN) begin
                  eRen = 1; eAddr = iaddr; nOwner = 1;
                  if (done) begin
                     eIwait = 0; eErr = (rsp != 2);
                     eIload = (rsp == 2) ? memWord(iaddr) : 0;
                     mStreak = 0; nOwner = 0;
                  end
               end
            end
            default: begin
               nOwner = 0;
               if (mdreq) begin
                  eAddr = daddr; eWen = dWEN; eRen = !dWEN; eStore = dWEN ? dstore : 0;
                  nOwner = 2;
                  if (done) begin
                     eDwait = 0; eErr = (rsp != 2);
                     eDload = (rsp == 2) ? memWord(daddr) : 0;
                     mStreak = iREN ? ((mStreak < MAX_DSTREAK) ? mStreak + 1 : mStreak) : 0;
                     nOwner = 0;
                  end
               end
            end
         endcase
         checkOutput("m_iwait", iwait, eIwait);
         checkOutput("m_dwait", dwait, eDwait);
         checkOutput("m_iload", iload, eIload);
         checkOutput("m_dload", dload, eDload);
         checkOutput("m_mem_err", mem_err, eErr);
         checkOutput("m_ramREN", ramREN, eRen);
         checkOutput("m_ramWEN", ramWEN, eWen);
         checkOutput("m_ramaddr", ramaddr, eAddr);
         checkOutput("m_ramstore", ramstore, eStore);
         mOwner = nOwner;
         cyc++;
      end
   end

   // Records the address of every new grant so the arbitration order can be pinned.
   logic [31:0] grantLog[$];
   bit prevStrobe = 1'b0;
   always @(negedge CLK) begin
      if (nRST && (ramREN | ramWEN) && !prevStrobe) grantLog.push_back(ramaddr);
      prevStrobe = nRST && (ramREN | ramWEN);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=%0d required=%0d", 0, 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] expGrant [6];
      int cnt;
      bit seen;
      expGrant = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h40, 32'h100};

      nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
      ramLat = 2; ramErr = 0;
      repeat (2) @(negedge CLK);
      checkOutput("rst_ramREN", ramREN, 0);
      checkOutput("rst_ramaddr", ramaddr, 0);
      checkOutput("rst_iwait", iwait, 1);
      checkOutput("rst_dwait", dwait, 0);
      checkOutput("rst_mem_err", mem_err, 0);
      checkOutput("rst_iload", iload, 0);
      @(posedge CLK); #1 nRST = 1'b1;

      // Instruction fetch, ACCESS on the second strobe cycle.
      @(negedge CLK);
      checkOutput("t1_arb_ramREN", ramREN, 0);
      checkOutput("t1_arb_iwait", iwait, 1);
      @(negedge CLK);
      checkOutput("t1_acc1_ramREN", ramREN, 1);
      checkOutput("t1_acc1_ramaddr", ramaddr, 32'h40);
      checkOutput("t1_acc1_iwait", iwait, 1);
      @(negedge CLK);
      checkOutput("t1_acc2_ramREN", ramREN, 1);
      checkOutput("t1_acc2_iwait", iwait, 0);
      checkOutput("t1_acc2_iload", iload, 32'h8C010004);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);
      checkOutput("t1_idle_ramREN", ramREN, 0);

      // Data streak limit against a waiting instruction fetch.
      grantLog.delete();
      applyStimulus(1, 32'h40, 1, 0, 32'h100, 0, 1, 0);
      repeat (12) @(negedge CLK);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);
      checkOutput("t2_grant_count", grantLog.size(), 6);
      for (int k = 0; k < 6; k++)
         checkOutput($sformatf("t2_grant%0d", k), (k < grantLog.size()) ? grantLog[k] : 32'hFFFF_FFFF, expGrant[k]);

      // Write wins over read.
      applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 2, 0);
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("t3_ramWEN", ramWEN, 1);
      checkOutput("t3_ramREN", ramREN, 0);
      checkOutput("t3_ramstore", ramstore, 32'hDEADBEEF);
      checkOutput("t3_ramaddr", ramaddr, 32'h200);
      checkOutput("t3_busy_dwait", dwait, 1);
      @(negedge CLK);
      checkOutput("t3_done_dwait", dwait, 0);
      checkOutput("t3_mem_err", mem_err, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);

      // RAM stuck BUSY: forced completion after TIMEOUT strobe cycles.
      applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
      cnt = 0; seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (ramREN) cnt++;
         if (!dwait) begin
            checkOutput("t4_mem_err", mem_err, 1);
            checkOutput("t4_dload", dload, 0);
            seen = 1;
            break;
         end
      end
      checkOutput("t4_timeout_seen", seen, 1);
      checkOutput("t4_ren_cycles", cnt, 64);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);
      checkOutput("t4_after_mem_err", mem_err, 0);
      checkOutput("t4_after_ramREN", ramREN, 0);

      // ERROR on the first access cycle.
      applyStimulus(1, 32'h80, 0, 0, 0, 0, 1, 1);
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("t5_iwait", iwait, 0);
      checkOutput("t5_mem_err", mem_err, 1);
      checkOutput("t5_iload", iload, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);
      checkOutput("t5_after_mem_err", mem_err, 0);

      // Data requester drops its request in the second access cycle.
      applyStimulus(0, 0, 1, 0, 32'h180, 0, 5, 0);
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("t6_acc_ramREN", ramREN, 1);
      applyStimulus(0, 0, 0, 0, 32'h180, 0, 5, 0);
      @(negedge CLK);
      checkOutput("t6_abort_ramREN", ramREN, 0);
      checkOutput("t6_abort_mem_err", mem_err, 0);
      @(negedge CLK);
      checkOutput("t6_idle_ramREN", ramREN, 0);

      // Asynchronous reset in the middle of an instruction access.
      applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("t7_acc_ramREN", ramREN, 1);
      checkOutput("t7_acc_ramaddr", ramaddr, 32'h44);
      #2 nRST = 1'b0;
      #1;
      checkOutput("t7_rst_ramREN", ramREN, 0);
      checkOutput("t7_rst_ramaddr", ramaddr, 0);
      ramLat = 1;
      @(posedge CLK); #3 nRST = 1'b1;
      @(negedge CLK);
      checkOutput("t7_arb_ramREN", ramREN, 0);
      checkOutput("t7_arb_iwait", iwait, 1);
      @(negedge CLK);
      checkOutput("t7_new_ramREN", ramREN, 1);
      checkOutput("t7_new_ramaddr", ramaddr, 32'h44);
      checkOutput("t7_new_iwait", iwait, 0);
      checkOutput("t7_new_iload", iload, memWord(32'h44));
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
